// File: rtl/config_multiplier_8b.sv
// Precision-configurable signed multiplier: one 8x8 product or two packed 4x4 products.
// Combinational result plus a registered copy for the pipelined accumulator path.
module config_multiplier_8b (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  multiplier,
    input  logic [7:0]  multiplicand,
    input  logic        halvedPrecision,
    output logic [15:0] product,
    output logic [15:0] product_q
);

    // 4x4 sub-multiplier; each operand is independently treated as signed or unsigned
    // by choosing its fifth (extension) bit, so one 5x5 signed multiply covers all cases.
    function automatic logic signed [9:0] mul4(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       a_signed,
        input logic       b_signed
    );
        logic signed [9:0] ax;
        logic signed [9:0] bx;
        ax = {{6{a_signed & a[3]}}, a};
        bx = {{6{b_signed & b[3]}}, b};
        return ax * bx;
    endfunction

    logic [3:0] a_hi, a_lo, b_hi, b_lo;
    logic signed [9:0] hh, hl, lh, ll;
    logic [15:0] hh16, hl16, lh16, ll16;
    logic [15:0] cross16;
    logic [15:0] full_product;
    logic [15:0] dual_product;

    assign a_hi = multiplier[7:4];
    assign a_lo = multiplier[3:0];
    assign b_hi = multiplicand[7:4];
    assign b_lo = multiplicand[3:0];

    always_comb begin
        hh = mul4(a_hi, b_hi, 1'b1, 1'b1);
        ll = mul4(a_lo, b_lo, halvedPrecision, halvedPrecision);
        hl = '0;
        lh = '0;
        if (!halvedPrecision) begin
            hl = mul4(a_hi, b_lo, 1'b1, 1'b0);
            lh = mul4(a_lo, b_hi, 1'b0, 1'b1);
        end
    end

    assign hh16    = {{6{hh[9]}}, hh};
    assign hl16    = {{6{hl[9]}}, hl};
    assign lh16    = {{6{lh[9]}}, lh};
    assign ll16    = {{6{ll[9]}}, ll};
    assign cross16 = hl16 + lh16;

    assign full_product = (hh16 << 8) + (cross16 << 4) + ll16;

    // Lanes are packed side by side so nothing carries across bit 7/8.
    assign dual_product = {hh[7:0], ll[7:0]};

    assign product = halvedPrecision ? dual_product : full_product;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            product_q <= 16'h0000;
        else
            product_q <= product;
    end

endmodule

// File: tb/tb_config_multiplier_8b.sv
// Directed and random checks of config_multiplier_8b in both precision modes and the register path.
module tb_config_multiplier_8b;

    logic        clk;
    logic        rst;
    logic [7:0]  multiplier;
    logic [7:0]  multiplicand;
    logic        halvedPrecision;
    logic [15:0] product;
    logic [15:0] product_q;

    int tests;
    int fails;

    config_multiplier_8b dut (
        .clk             (clk),
        .rst             (rst),
        .multiplier      (multiplier),
        .multiplicand    (multiplicand),
        .halvedPrecision (halvedPrecision),
        .product         (product),
        .product_q       (product_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        multiplier = 8'h00;
        multiplicand = 8'h00;
        halvedPrecision = 1'b0;
        #1;
        tests++;
        if (product_q !== 16'h0000) begin
            fails++;
            $display("FAIL reset_q: got %h expected %h", product_q, 16'h0000);
        end
        @(posedge clk); #1;
        tests++;
        if (product_q !== 16'h0000) begin
            fails++;
            $display("FAIL reset_hold: got %h expected %h", product_q, 16'h0000);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mode0_directed();
        logic [7:0]  av [6] = '{8'h80, 8'h01, 8'h7F, 8'hFF, 8'hFF, 8'h80};
        logic [7:0]  bv [6] = '{8'h10, 8'h02, 8'h7F, 8'h05, 8'hFF, 8'hFF};
        logic [15:0] ev [6] = '{16'hF800, 16'h0002, 16'h3F01, 16'hFFFB, 16'h0001, 16'h0080};
        halvedPrecision = 1'b0;
        for (int i = 0; i < 6; i++) begin
            multiplier = av[i];
            multiplicand = bv[i];
            #1;
            tests++;
            if (product !== ev[i]) begin
                fails++;
                $display("FAIL mode0_dir[%0d] %h*%h: got %h expected %h", i, av[i], bv[i], product, ev[i]);
            end
        end
    endtask

    task automatic test_mode1_lanes();
        logic [7:0]  av [6] = '{8'h00, 8'h13, 8'h77, 8'hFF, 8'h44, 8'h88};
        logic [7:0]  bv [6] = '{8'h00, 8'h24, 8'h79, 8'h55, 8'hE2, 8'h87};
        logic [15:0] ev [6] = '{16'h0000, 16'h020C, 16'h31CF, 16'hFBFB, 16'hF808, 16'h40C8};
        halvedPrecision = 1'b1;
        for (int i = 0; i < 6; i++) begin
            multiplier = av[i];
            multiplicand = bv[i];
            #1;
            tests++;
            if (product !== ev[i]) begin
                fails++;
                $display("FAIL mode1_lane[%0d] %h*%h: got %h expected %h", i, av[i], bv[i], product, ev[i]);
            end
        end
    endtask

    task automatic test_random_mode0();
        logic signed [7:0]  a;
        logic signed [7:0]  b;
        logic signed [15:0] ref_p;
        halvedPrecision = 1'b0;
        for (int i = 0; i < 120; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            multiplier = a;
            multiplicand = b;
            ref_p = a * b;
            #1;
            tests++;
            if (product !== ref_p) begin
                fails++;
                $display("FAIL random_mode0 %h*%h: got %h expected %h", a, b, product, ref_p);
            end
        end
    endtask

    task automatic test_mode_toggle();
        multiplier = 8'h7F;
        multiplicand = 8'h7F;
        halvedPrecision = 1'b0;
        #1;
        tests++;
        if (product !== 16'h3F01) begin
            fails++;
            $display("FAIL toggle_m0: got %h expected %h", product, 16'h3F01);
        end
        halvedPrecision = 1'b1;
        #1;
        // upper lane 7*7 = 49, lower lane (-1)*(-1) = +1
        tests++;
        if (product !== 16'h3101) begin
            fails++;
            $display("FAIL toggle_m1: got %h expected %h", product, 16'h3101);
        end
        halvedPrecision = 1'b0;
        #1;
        tests++;
        if (product !== 16'h3F01) begin
            fails++;
            $display("FAIL toggle_back: got %h expected %h", product, 16'h3F01);
        end
    endtask

    task automatic test_register_path();
        @(negedge clk);
        halvedPrecision = 1'b0;
        multiplier = 8'h40;
        multiplicand = 8'h02;
        @(posedge clk); #1;
        tests++;
        if (product_q !== 16'h0080) begin
            fails++;
            $display("FAIL reg_load: got %h expected %h", product_q, 16'h0080);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (product_q !== 16'h0000) begin
            fails++;
            $display("FAIL reg_async_clear: got %h expected %h", product_q, 16'h0000);
        end
        tests++;
        if (product !== 16'h0080) begin
            fails++;
            $display("FAIL comb_during_rst: got %h expected %h", product, 16'h0080);
        end
        @(posedge clk); #1;
        tests++;
        if (product_q !== 16'h0000) begin
            fails++;
            $display("FAIL reg_hold_in_rst: got %h expected %h", product_q, 16'h0000);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (product_q !== 16'h0000) begin
            fails++;
            $display("FAIL reg_before_edge: got %h expected %h", product_q, 16'h0000);
        end
        @(posedge clk); #1;
        tests++;
        if (product_q !== 16'h0080) begin
            fails++;
            $display("FAIL reg_reload: got %h expected %h", product_q, 16'h0080);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  av [3] = '{8'h03, 8'hFE, 8'h80};
        logic [7:0]  bv [3] = '{8'h05, 8'h07, 8'h80};
        logic [15:0] ev [3] = '{16'h000F, 16'hFFF2, 16'h4000};
        halvedPrecision = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            multiplier = av[i];
            multiplicand = bv[i];
            @(posedge clk); #1;
            tests++;
            if (product_q !== ev[i]) begin
                fails++;
                $display("FAIL b2b_q[%0d]: got %h expected %h", i, product_q, ev[i]);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_mode0_directed();
        test_mode1_lanes();
        test_random_mode0();
        test_mode_toggle();
        test_register_path();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
